// File: rtl/ldpc_15_7_pkg.sv
// Shared constants for the (15,7) bit-flipping decoder: check masks, column
// check sets, the flip-select helper and the FSM state type.
package ldpc_15_7_pkg;

  localparam int NIN  = 7;
  localparam int NOUT = 15;
  localparam int NCHK = 8;

  // Bits [6:0] are i0..i6 and bits [14:7] are p0..p7; check k also covers p_k.
  localparam logic [NOUT-1:0] CHK_MASK [0:NCHK-1] = '{
    15'h00D1, 15'h0173, 15'h0237, 15'h046E,
    15'h080D, 15'h101A, 15'h2034, 15'h4068
  };

  localparam logic [NCHK-1:0] COL_SET [0:NOUT-1] = '{
    8'h17, 8'h2E, 8'h5C, 8'hB8, 8'h67, 8'hCE, 8'h8B,
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DONE
  } dec_state_t;

  // One-hot mask of the lowest-index bit whose whole check set is unsatisfied.
  // The scan runs high to low so the lowest qualifying index wins.
  function automatic logic [NOUT-1:0] flip_mask(input logic [NCHK-1:0] s);
    logic [NOUT-1:0] m;
    m = '0;
    for (int j = NOUT - 1; j >= 0; j--) begin
      if ((COL_SET[j] & ~s) == '0) begin
        m    = '0;
        m[j] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ldpc_syndrome_15_7.sv
// Combinational syndrome of a (15,7) word; s[k]=1 means check k is unsatisfied.
module ldpc_syndrome_15_7
  import ldpc_15_7_pkg::*;
(
  input  logic [NOUT-1:0] word,
  output logic [NCHK-1:0] s
);

  always_comb begin
    s = '0;
    for (int k = 0; k < NCHK; k++) begin
      s[k] = ^(word & CHK_MASK[k]);
    end
  end

endmodule

// File: rtl/ldpc_decoder_15_7.sv
// Hard-decision bit-flipping decoder for the systematic (15,7) code.
// Optional saturating word/failure counters under LDPC_DEC_STATS_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a received word, in_ready=1
// ST_CHECK | evaluate syndrome, flip one bit per cycle until clean or out of budget
// ST_DONE  | result presented on out_valid until out_ready
module ldpc_decoder_15_7
  import ldpc_15_7_pkg::*;
#(
  parameter int MAX_ITER = 8,
  parameter int ITW      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NOUT-1:0] in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NIN-1:0]  dec_out,
  output logic            dec_ok,
  output logic [ITW-1:0]  dec_iters
`ifdef LDPC_DEC_STATS_EN
  ,
  output logic [15:0]     stat_words,
  output logic [15:0]     stat_fails
`endif
);

  dec_state_t      state_q, state_d;
  logic [NOUT-1:0] word_q, word_d;
  logic [ITW-1:0]  iter_q, iter_d;
  logic            ok_q, ok_d;
  logic [NCHK-1:0] syn;

  ldpc_syndrome_15_7 u_syndrome (
    .word (word_q),
    .s    (syn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      iter_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      iter_q  <= iter_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    iter_d  = iter_q;
    ok_d    = ok_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          iter_d  = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (syn == '0) begin
          ok_d    = 1'b1;
          state_d = ST_DONE;
        end else if (iter_q == ITW'(MAX_ITER)) begin
          ok_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          word_d = word_q ^ flip_mask(syn);
          iter_d = iter_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dec_out   = word_q[NIN-1:0];
  assign dec_ok    = ok_q;
  assign dec_iters = iter_q;

`ifdef LDPC_DEC_STATS_EN
  logic handshake;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words <= '0;
      stat_fails <= '0;
    end else if (handshake) begin
      if (stat_words != 16'hFFFF) stat_words <= stat_words + 16'd1;
      if (!ok_q && stat_fails != 16'hFFFF) stat_fails <= stat_fails + 16'd1;
    end
  end
`endif

endmodule
